// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-port SPI flash pin arbiter with guard time and watchdog
module spi_flash_arbiter #(
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [1:0] timeout_err,
    input  logic [1:0] req_csn,
    input  logic [1:0] req_sck,
    input  logic [1:0] req_dq0,
    input  logic [1:0] req_wpn,
    input  logic [1:0] req_hldn,
    output logic [1:0] req_dq1,
    output logic       flash_csn,
    output logic       flash_sck,
    output logic       flash_dq0,
    output logic       flash_wpn,
    output logic       flash_hldn,
    input  logic       flash_dq1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Guard counter counts down from GUARD_CYCLES-1 so the state lasts GUARD_CYCLES cycles.
    localparam logic [TO_W-1:0] GUARD_LOAD = TO_W'(GUARD_CYCLES - 1);
    // Last grant cycle allowed before eviction; the counter reads 0 on the first grant cycle.
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit              WD_EN      = (TIMEOUT_CYCLES != 0);

    state_t          state;
    logic            owner;
    logic            last;
    logic [1:0]      lockout;
    logic [TO_W-1:0] counter;

    logic [1:0]      eligible;
    logic            pick;
    logic            release_now;
    logic            watchdog_now;

    // Arbitration and exit conditions derived from the current registered state.
    always_comb begin
        eligible     = req & ~lockout;
        pick         = 1'b0;
        if (eligible == 2'b11) begin
            pick = ~last;
        end else if (eligible[1]) begin
            pick = 1'b1;
        end
        release_now  = ~req[owner];
        watchdog_now = WD_EN && (counter == TO_LAST);
    end

    assign busy = (state != IDLE);

    // Single FSM: ownership, guard timing, watchdog and registered pin muxing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            lockout     <= 2'b00;
            counter     <= '0;
            gnt         <= 2'b00;
            timeout_err <= 2'b00;
            req_dq1     <= 2'b00;
            flash_csn   <= 1'b1;
            flash_sck   <= 1'b0;
            flash_dq0   <= 1'b0;
            flash_wpn   <= 1'b1;
            flash_hldn  <= 1'b1;
        end else begin
            // Idle pin values unless a continuing owner overrides them below;
            // this also forces csn high on an abort.
            timeout_err <= 2'b00;
            req_dq1     <= 2'b00;
            flash_csn   <= 1'b1;
            flash_sck   <= 1'b0;
            flash_dq0   <= 1'b0;
            flash_wpn   <= 1'b1;
            flash_hldn  <= 1'b1;
            // A requester clears its own lockout by dropping req for a cycle.
            lockout     <= lockout & req;

            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state   <= GRANT;
                        owner   <= pick;
                        gnt     <= pick ? 2'b10 : 2'b01;
                        counter <= '0;
                    end
                end

                GRANT: begin
                    if (release_now) begin
                        // Release beats the watchdog when both happen together.
                        state   <= GUARD;
                        gnt     <= 2'b00;
                        last    <= owner;
                        counter <= GUARD_LOAD;
                    end else if (watchdog_now) begin
                        state                <= GUARD;
                        gnt                  <= 2'b00;
                        last                 <= owner;
                        counter              <= GUARD_LOAD;
                        timeout_err[owner]   <= 1'b1;
                        lockout[owner]       <= 1'b1;
                    end else begin
                        if (counter != '1) begin
                            counter <= counter + 1'b1;
                        end
                        flash_csn      <= req_csn[owner];
                        flash_sck      <= req_sck[owner];
                        flash_dq0      <= req_dq0[owner];
                        flash_wpn      <= req_wpn[owner];
                        flash_hldn     <= req_hldn[owner];
                        req_dq1[owner] <= flash_dq1;
                    end
                end

                GUARD: begin
                    if (counter == '0) begin
                        state <= IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
Shares one physical SPI flash port between two requesters: port 0 is the JTAG-bridged SPI engine, port 1 is a fabric-side flash reader. Requesters handshake with req/gnt, and only the granted requester's pin signals reach the flash. Ownership changes only on transaction boundaries, with an enforced chip-select-high guard time. A watchdog forcibly reclaims the flash from a requester that holds it too long.

Parameters:
GUARD_CYCLES, 4, clk cycles flash_csn is held high, with sck low, after every release before a new grant (min 1).
TIMEOUT_CYCLES, 65535, maximum clk cycles one grant may last; 0 disables the watchdog.
TO_W, 16, width of the grant/timeout counter; must hold max(GUARD_CYCLES, TIMEOUT_CYCLES).

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous reset, active-high.
req  in  2  per-requester access request; bit n is requester n.
gnt  out  2  one-hot-or-zero grant.
busy  out  1  high in any state other than IDLE.
timeout_err  out  2  one-cycle pulse on bit n when requester n is evicted by the watchdog.
req_csn  in  2  requester chip selects.
req_sck  in  2  requester SPI clocks.
req_dq0  in  2  requester MOSI.
req_wpn  in  2  requester write-protect (dq2).
req_hldn  in  2  requester hold (dq3).
req_dq1  out  2  MISO returned to requesters; a non-owner's bit is 0.
flash_csn  out  1  to flash/STARTUP FCSBO.
flash_sck  out  1  to flash/STARTUP USRCCLKO.
flash_dq0  out  1  flash MOSI.
flash_wpn  out  1  flash dq2.
flash_hldn  out  1  flash dq3.
flash_dq1  in  1  flash MISO.

Behaviour:
- Idle pin values (during reset, IDLE and GUARD): flash_csn=1, flash_sck=0, flash_dq0=0, flash_wpn=1, flash_hldn=1.
- Reset values: gnt=00, busy=0, timeout_err=00, req_dq1=00, last=1 (port 0 wins the first contention), lockout=00, counter=0.
- Flash outputs are registered: the owner's req_* values appear on flash_* one cycle later. req_dq1[owner] is registered from flash_dq1 (1-cycle latency); the requester accounts for this.
- State IDLE:
  - Request from one port n with lockout[n]=0 -> GRANT_n next cycle; gnt[n]=1 from that cycle.
  - Both ports eligible -> grant the port != last (round robin).
  - A port with lockout set is ignored.
- State GRANT_n:
  - Counter increments each cycle.
  - Flash pins follow requester n.
  - Normal release: req[n]=0 while req_csn[n]=1 -> GUARD next cycle; gnt=00; last=n.
  - Abort: req[n]=0 while req_csn[n]=0 -> same as normal release, with flash_csn forced high in the same registered update.
  - Watchdog: TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 -> GUARD; gnt=00; timeout_err[n] pulses one cycle; lockout[n]=1; last=n.
  - Watchdog and release in the same cycle: release wins, no error pulse.
- State GUARD:
  - Idle pin values are driven; the counter is reloaded at entry.
  - After GUARD_CYCLES cycles -> IDLE.
  - Requests arriving during GUARD are held pending and granted from IDLE; the earliest gnt is 1 cycle after GUARD exit.
- Lockout: lockout[n] clears on any cycle with req[n]=0. A timed-out requester must drop req for at least 1 cycle before it is granted again.
- gnt[n] never asserts while the other bit is high. gnt never rises while flash_csn=0.
- The requester toggles sck/csn only while gnt is high. Activity on req_* from a non-owner is ignored.
- rst asserted mid-transaction: the next edge forces idle pin values, gnt=00 and FSM=IDLE. There is no guard period after reset.
- The counter saturates and never wraps.

Test Plan:
- Single requester: req=01 at cycle 0 -> gnt=01 at cycle 1; req_csn[0]=0 at cycle 2 -> flash_csn=0 at cycle 3; drop req with csn high -> gnt=00, then flash_csn=1 for exactly 4 cycles, busy=0 afterwards.
- Contention and round robin: after reset, req=11 -> port 0 granted first; on release, port 1 is granted exactly 1 cycle after GUARD ends; a third contention goes to port 0.
- Isolation: while port 1 is owner, toggle req_sck[0]/req_csn[0] -> flash pins track only port 1; req_dq1[0]=0 while flash_dq1=1.
- Abort: port 0 drops req with req_csn[0]=0 -> flash_csn=1 on the next edge, followed by a 4-cycle guard.
- Watchdog (TIMEOUT_CYCLES=16): port 1 holds req -> after 16 grant cycles gnt=00 and timeout_err=10 for 1 cycle; port 1 is not regranted until req[1] drops for ≥1 cycle; port 0's pending request is granted right after the guard.
- Reset mid-transfer: assert rst while flash_csn=0 -> next edge gives flash_csn=1, sck=0, gnt=00, busy=0.
